// File: rtl/mmio_master_pkg.sv
// mmio_master_pkg: shared op codes, FSM encodings and limits for mmio_bus_master
package mmio_master_pkg;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RMW   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_STB  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_MODIFY  = 3'd3;
  localparam logic [2:0] ST_WR_STB  = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_STB  = ST_RD_STB,
    S_RD_WAIT = ST_RD_WAIT,
    S_MODIFY  = ST_MODIFY,
    S_WR_STB  = ST_WR_STB,
    S_RESP    = ST_RESP
  } state_t;
  localparam int RD_LAT_MAX = 7;
endpackage

// File: rtl/mmio_bus_master.sv
// mmio_bus_master: single-command initiator for the cs/read/write MMIO register bus
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data/cmd_mask command in;
//   rsp_valid/rsp_ready/rsp_data/rsp_err response out; cs/read/write/reg_addr/wr_data bus out; rd_data bus in.
// Build option: define MMIO_RMW_EN to make op 2'b10 a read-modify-write; otherwise it is rejected as illegal.
module mmio_bus_master
  import mmio_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  cs,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data
);
  // counter is loaded with latency-1 in the strobe cycle so it hits 0 in the sample cycle
  localparam logic [2:0] LAT_LOAD = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);
  state_t                r_state;
  logic [2:0]            r_cnt;
  logic                  r_cmd_ready, r_rsp_valid, r_rsp_err, r_cs, r_read, r_write;
  logic [DATA_WIDTH-1:0] r_rsp_data, r_wr_data;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic                  w_legal, w_write, w_sample;
`ifdef MMIO_RMW_EN
  logic                  r_rmw;
  logic [DATA_WIDTH-1:0] r_data, r_mask;
  assign w_legal = op_t'(cmd_op) != OP_RSVD;
`else
  logic                  w_unused_mask;
  assign w_unused_mask = ^cmd_mask;
  assign w_legal = op_t'(cmd_op) inside {OP_READ, OP_WRITE};
`endif
  assign w_write  = op_t'(cmd_op) == OP_WRITE;
  assign w_sample = (r_state == S_RD_STB && RD_LATENCY == 0) || (r_state == S_RD_WAIT && r_cnt == 3'd0);
  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign cs        = r_cs;
  assign read      = r_read;
  assign write     = r_write;
  assign reg_addr  = r_reg_addr;
  assign wr_data   = r_wr_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_cs        <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_reg_addr  <= '0;
      r_wr_data   <= '0;
`ifdef MMIO_RMW_EN
      r_rmw       <= 1'b0;
      r_data      <= '0;
      r_mask      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_cmd_ready <= 1'b0;
          r_rsp_data  <= '0;
          r_rsp_err   <= !w_legal;
`ifdef MMIO_RMW_EN
          r_rmw       <= op_t'(cmd_op) == OP_RMW;
          r_data      <= cmd_data;
          r_mask      <= cmd_mask;
`endif
          if (!w_legal) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cs       <= 1'b1;
            r_read     <= !w_write;
            r_write    <= w_write;
            r_reg_addr <= cmd_addr;
            r_wr_data  <= w_write ? cmd_data : r_wr_data;
            r_state    <= w_write ? S_WR_STB : S_RD_STB;
          end
        end
        S_RD_STB, S_RD_WAIT: begin
          r_cs   <= 1'b0;
          r_read <= 1'b0;
          r_cnt  <= w_sample ? 3'd0 : (r_state == S_RD_STB ? LAT_LOAD : r_cnt - 3'd1);
          if (w_sample) begin
            r_rsp_data  <= rd_data;
`ifdef MMIO_RMW_EN
            r_rsp_valid <= !r_rmw;
            r_state     <= r_rmw ? S_MODIFY : S_RESP;
`else
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
`endif
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
`ifdef MMIO_RMW_EN
        // r_rsp_data still holds the pre-modify read value, which is also the response
        S_MODIFY: begin
          r_wr_data <= (r_rsp_data & ~r_mask) | (r_data & r_mask);
          r_cs      <= 1'b1;
          r_write   <= 1'b1;
          r_state   <= S_WR_STB;
        end
`endif
        S_WR_STB: begin
          r_cs        <= 1'b0;
          r_write     <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
